// File: rtl/audio_sram_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : audio_sram_pkg                                              |
// | Shared types and default widths for the audio SRAM arbiter slice:     |
// |   arb_state_e - arbiter FSM states                                    |
// |   arb_sel_e   - which requester was granted last                      |
// |   max_u       - helper used to size the shared hold/latency counter   |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package audio_sram_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WDONE = 3'd2,
        READ  = 3'd3,
        RDONE = 3'd4
    } arb_state_e;

    typedef enum logic {
        SEL_WR = 1'b0,
        SEL_RD = 1'b1
    } arb_sel_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_sram_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Interface : audio_sram_arbiter_if                                     |
// | Requester-side handshake bundle of the audio SRAM arbiter.            |
// |   wr_req/wr_addr/wr_data -> wr_ack      recorder write channel       |
// |   rd_req/rd_addr         -> rd_data/rd_valid   player read channel   |
// | Modports: master (requesters), slave (arbiter).                       |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
interface audio_sram_arbiter_if
    import audio_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_data, rd_valid
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/audio_sram_arbiter_sat_counter16.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : sat_counter16                                                |
// | 16-bit up counter that sticks at 0xFFFF; clear has priority over      |
// | increment.                                                            |
// |   i_clk, i_rst_n (async, active-low)                                  |
// |   i_clr  synchronous clear      i_inc  count enable                   |
// |   o_cnt  current count                                                |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module sat_counter16 (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    input  wire logic        i_clr,
    input  wire logic        i_inc,
    output logic [15:0]      o_cnt
);
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = 16'h0000;
        end else if (i_inc && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
endmodule
`default_nettype wire

// File: rtl/audio_sram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : audio_sram_arbiter                                           |
// | Shares one single-port 16-bit audio SRAM between the recorder (write) |
// | and the player/DSP (read). Round-robin grant in IDLE, fixed WE_N      |
// | strobe length (WR_HOLD) and read capture latency (RD_LAT).            |
// | Ports:                                                                |
// |   i_clk, i_rst_n          clock, asynchronous active-low reset        |
// |   bus (slave)             requester handshakes (wr/rd channels)       |
// |   o_busy                  transaction in progress                     |
// |   i_stats_clr             clear stall counters                        |
// |   o_wr/rd_stall_cnt       stall cycle counters                        |
// |   o_SRAM_*, io_SRAM_DQ    SRAM pins (all owned here)                  |
// | Build option: AUDIO_SRAM_ARB_STATS_EN builds the stall counters;      |
// |   otherwise they read 0 and i_stats_clr is ignored.                   |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module audio_sram_arbiter
    import audio_sram_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned WR_HOLD = 2,
    parameter int unsigned RD_LAT  = 2
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    audio_sram_arbiter_if.slave    bus,
    output logic                   o_busy,
    input  wire logic              i_stats_clr,
    output logic [15:0]            o_wr_stall_cnt,
    output logic [15:0]            o_rd_stall_cnt,
    output logic [ADDR_W-1:0]      o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0]      io_SRAM_DQ,
    output logic                   o_SRAM_WE_N,
    output logic                   o_SRAM_OE_N,
    output logic                   o_SRAM_CE_N,
    output logic                   o_SRAM_LB_N,
    output logic                   o_SRAM_UB_N
);
    // One counter times both the write strobe and the read latency.
    localparam int unsigned MAX_HOLD = max_u(WR_HOLD, RD_LAT);
    localparam int unsigned CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] c_wr_last = CNT_W'(WR_HOLD - 1);
    localparam logic [CNT_W-1:0] c_rd_last = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    arb_state_e         state_q, state_d;
    arb_sel_e           last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_wr, grant_rd, capture;

    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;

    // Pin strobes are registered from the next state so they never glitch.
    logic we_n_q, we_n_d;
    logic oe_n_q, oe_n_d;
    logic dq_oe_q, dq_oe_d;
    logic ack_q, ack_d;
    logic valid_q, valid_d;
    logic busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Write wins unless the read is also pending and writes went last.
                if (bus.wr_req && (!bus.rd_req || (last_q == SEL_RD))) begin
                    state_d  = WRITE;
                    last_d   = SEL_WR;
                    cnt_d    = '0;
                    grant_wr = 1'b1;
                end else if (bus.rd_req) begin
                    state_d  = READ;
                    last_d   = SEL_RD;
                    cnt_d    = '0;
                    grant_rd = 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q == c_wr_last) state_d = WDONE;
                else                    cnt_d   = cnt_q + c_one;
            end
            WDONE: state_d = IDLE;
            READ: begin
                if (cnt_q == c_rd_last) state_d = RDONE;
                else                    cnt_d   = cnt_q + c_one;
            end
            RDONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        capture = (state_q == READ) && (state_d == RDONE);
        we_n_d  = (state_d != WRITE);
        oe_n_d  = (state_d != READ);
        dq_oe_d = (state_d == WRITE) || (state_d == WDONE);
        ack_d   = (state_d == WDONE);
        valid_d = (state_d == RDONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= SEL_RD;
            cnt_q   <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            dq_oe_q <= dq_oe_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            if (grant_wr) begin
                addr_q  <= bus.wr_addr;
                wdata_q <= bus.wr_data;
            end else if (grant_rd) begin
                addr_q  <= bus.rd_addr;
            end
            if (capture) begin
                rdata_q <= io_SRAM_DQ;
            end
        end
    end

    assign io_SRAM_DQ   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign o_SRAM_ADDR  = addr_q;
    assign o_SRAM_WE_N  = we_n_q;
    assign o_SRAM_OE_N  = oe_n_q;
    assign o_SRAM_CE_N  = 1'b0;
    assign o_SRAM_LB_N  = 1'b0;
    assign o_SRAM_UB_N  = 1'b0;
    assign o_busy       = busy_q;
    assign bus.wr_ack   = ack_q;
    assign bus.rd_valid = valid_q;
    assign bus.rd_data  = rdata_q;

`ifdef AUDIO_SRAM_ARB_STATS_EN
    // A requester stalls every cycle its request is up outside its own transaction.
    logic wr_stall;
    logic rd_stall;
    assign wr_stall = bus.wr_req && !((state_q == WRITE) || (state_q == WDONE));
    assign rd_stall = bus.rd_req && !((state_q == READ)  || (state_q == RDONE));

    sat_counter16 u_wr_stall (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_stats_clr),
        .i_inc   (wr_stall),
        .o_cnt   (o_wr_stall_cnt)
    );

    sat_counter16 u_rd_stall (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_stats_clr),
        .i_inc   (rd_stall),
        .o_cnt   (o_rd_stall_cnt)
    );
`else
    logic unused_stats_clr;
    assign unused_stats_clr = i_stats_clr;
    assign o_wr_stall_cnt   = 16'h0000;
    assign o_rd_stall_cnt   = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_sram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Testbench : tb_audio_sram_arbiter                                     |
// | Directed checks of audio_sram_arbiter (WR_HOLD=2, RD_LAT=2) against a |
// | small behavioural SRAM. A pull-up on DQ makes an undriven bus read    |
// | as 0xFFFF. Stall-counter checks follow AUDIO_SRAM_ARB_STATS_EN.       |
// | Revision: 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module tb_audio_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stats_clr;
    logic        busy;
    logic [15:0] wr_stall_cnt, rd_stall_cnt;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n;

    int n_checks = 0;
    int n_errors = 0;

    audio_sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

    audio_sram_arbiter #(
        .ADDR_W(20), .DATA_W(16), .WR_HOLD(2), .RD_LAT(2)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus),
        .o_busy         (busy),
        .i_stats_clr    (stats_clr),
        .o_wr_stall_cnt (wr_stall_cnt),
        .o_rd_stall_cnt (rd_stall_cnt),
        .o_SRAM_ADDR    (sram_addr),
        .io_SRAM_DQ     (sram_dq),
        .o_SRAM_WE_N    (sram_we_n),
        .o_SRAM_OE_N    (sram_oe_n),
        .o_SRAM_CE_N    (sram_ce_n),
        .o_SRAM_LB_N    (sram_lb_n),
        .o_SRAM_UB_N    (sram_ub_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: 64 words, preloaded with 0x1234 at 0x20.
    logic [15:0] mem [0:63];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
            mem[32]    <= 16'h1234;
            mem_loaded <= 1'b1;
        end else if (!sram_we_n) begin
            mem[sram_addr[5:0]] <= sram_dq;
        end
    end
    pullup (sram_dq);
    assign sram_dq = (!sram_oe_n) ? mem[sram_addr[5:0]] : 16'hzzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gi;
        int conflicts;
        logic [3:0] order;

        rst_n         = 1'b1;
        stats_clr     = 1'b0;
        bus.wr_req    = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_req    = 1'b0;
        bus.rd_addr   = '0;
        #1 rst_n = 1'b0;
        #2;
        // ---- reset state ----
        chk("rst_we_n",  sram_we_n, 1);
        chk("rst_oe_n",  sram_oe_n, 1);
        chk("rst_dq_z",  sram_dq, 16'hFFFF);
        chk("rst_addr",  sram_addr, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_ack",   bus.wr_ack, 0);
        chk("rst_valid", bus.rd_valid, 0);
        chk("rst_rdata", bus.rd_data, 0);
        chk("tied_ctl",  {sram_ce_n, sram_lb_n, sram_ub_n}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---- single write: 0xA5A5 to 0x00010 ----
        bus.wr_req  = 1'b1;
        bus.wr_addr = 20'h00010;
        bus.wr_data = 16'hA5A5;
        chk("w_c0_we_n", sram_we_n, 1);
        tick();
        chk("w_c1_we_n", sram_we_n, 0);
        chk("w_c1_dq",   sram_dq, 16'hA5A5);
        chk("w_c1_addr", sram_addr, 20'h00010);
        chk("w_c1_oe_n", sram_oe_n, 1);
        chk("w_c1_ack",  bus.wr_ack, 0);
        chk("w_c1_busy", busy, 1);
        tick();
        chk("w_c2_we_n", sram_we_n, 0);
        chk("w_c2_ack",  bus.wr_ack, 0);
        tick();
        chk("w_c3_we_n", sram_we_n, 1);
        chk("w_c3_dq",   sram_dq, 16'hA5A5);
        chk("w_c3_ack",  bus.wr_ack, 1);
        bus.wr_req = 1'b0;
        tick();
        chk("w_c4_ack",  bus.wr_ack, 0);
        chk("w_c4_dq_z", sram_dq, 16'hFFFF);
        chk("w_c4_busy", busy, 0);
        chk("w_mem",     mem[16], 16'hA5A5);

        // ---- single read from 0x00020 ----
        bus.rd_req  = 1'b1;
        bus.rd_addr = 20'h00020;
        tick();
        chk("r_c1_oe_n",  sram_oe_n, 0);
        chk("r_c1_we_n",  sram_we_n, 1);
        chk("r_c1_addr",  sram_addr, 20'h00020);
        tick();
        chk("r_c2_oe_n",  sram_oe_n, 0);
        chk("r_c2_valid", bus.rd_valid, 0);
        tick();
        chk("r_c3_oe_n",  sram_oe_n, 1);
        chk("r_c3_valid", bus.rd_valid, 1);
        chk("r_c3_data",  bus.rd_data, 16'h1234);
        bus.rd_req = 1'b0;
        tick();
        chk("r_c4_valid", bus.rd_valid, 0);
        chk("r_c4_hold",  bus.rd_data, 16'h1234);

        // ---- asynchronous reset in the middle of a write ----
        bus.wr_req  = 1'b1;
        bus.wr_addr = 20'h00040;
        bus.wr_data = 16'h1111;
        tick();
        chk("mr_we_n_pre", sram_we_n, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_we_n", sram_we_n, 1);
        chk("mr_oe_n", sram_oe_n, 1);
        chk("mr_dq_z", sram_dq, 16'hFFFF);
        bus.wr_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_busy",  busy, 0);
        chk("mr_rdata", bus.rd_data, 0);

        // ---- both requests together straight after reset ----
        bus.wr_req  = 1'b1;
        bus.wr_addr = 20'h00030;
        bus.wr_data = 16'h5A5A;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 20'h00020;
        tick();
        chk("b_c1_we_n", sram_we_n, 0);
        chk("b_c1_oe_n", sram_oe_n, 1);
        tick();
        tick();
        chk("b_c3_ack",  bus.wr_ack, 1);
        bus.wr_req = 1'b0;
        tick();
        chk("b_c4_oe_n", sram_oe_n, 1);
`ifdef AUDIO_SRAM_ARB_STATS_EN
        chk("b_c4_rd_stall", rd_stall_cnt, 4);
`else
        chk("b_c4_rd_stall_tied", rd_stall_cnt, 0);
`endif
        tick();
        chk("b_c5_oe_n",  sram_oe_n, 0);
        chk("b_c5_addr",  sram_addr, 20'h00020);
        tick();
        chk("b_c6_oe_n",  sram_oe_n, 0);
        tick();
        chk("b_c7_valid", bus.rd_valid, 1);
        chk("b_c7_data",  bus.rd_data, 16'h1234);
        bus.rd_req = 1'b0;
        stats_clr  = 1'b1;
        tick();
        stats_clr  = 1'b0;
        chk("clr_rd_stall", rd_stall_cnt, 0);
        chk("clr_wr_stall", wr_stall_cnt, 0);

        // ---- both held: four transactions alternate W,R,W,R ----
        bus.wr_req  = 1'b1;
        bus.wr_addr = 20'h00010;
        bus.wr_data = 16'hBEEF;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 20'h00010;
        gi        = 0;
        conflicts = 0;
        order     = 4'b0000;
        for (int c = 0; c < 40 && gi < 4; c++) begin
            tick();
            if (!sram_we_n && !sram_oe_n) conflicts++;
            if (bus.wr_ack) begin
                order[gi] = 1'b0;
                gi++;
            end else if (bus.rd_valid) begin
                if (gi == 1) chk("alt_rdata", bus.rd_data, 16'hBEEF);
                order[gi] = 1'b1;
                gi++;
            end
        end
        chk("alt_count", gi, 4);
        chk("alt_order", order, 4'b1010);
        chk("alt_excl",  conflicts, 0);

`ifdef AUDIO_SRAM_ARB_STATS_EN
        // ---- saturation: requests still held ----
        force dut.u_rd_stall.cnt_q = 16'hFFFF;
        #1;
        release dut.u_rd_stall.cnt_q;
        tick();
        tick();
        chk("sat_rd_stall", rd_stall_cnt, 16'hFFFF);
`else
        tick();
        tick();
        chk("tied_wr_stall", wr_stall_cnt, 0);
`endif
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        chk("end_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
